// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad scanner with debounce, key decode and hex digit assembly.
// Define KEYPAD_DIGIT_LIMIT_EN to ignore digit keys once four digits are held.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV   = 20000,
    parameter int DEB_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row,
    input  logic [3:0]  col,
    input  logic        rd_ack,
    output logic [15:0] keyboard_read_data,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        data_ready,
    output logic [2:0]  digit_cnt
);
    localparam logic [2:0] SCAN     = 3'd0;
    localparam logic [2:0] DEBOUNCE = 3'd1;
    localparam logic [2:0] ACCEPT   = 3'd2;
    localparam logic [2:0] HOLD     = 3'd3;
    localparam logic [2:0] RELEASE  = 3'd4;
    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST = BW'(DEB_CYCLES - 1);
    // Nibble {row,col} holds the code printed on that key; * is E, # is F.
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    logic [3:0]    col_m_q, col_s_q;
    logic [2:0]    state_q, state_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [1:0]    cap_col_q, cap_col_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] deb_q, deb_d;
    logic [15:0]   data_q, data_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          data_ready_q, data_ready_d;
    logic [2:0]    digit_cnt_q, digit_cnt_d;
    logic          new_entry_q, new_entry_d;
    logic [1:0]    low_col;
    logic          all_high, cap_high, accept;

    always_comb begin
        all_high   = col_s_q == 4'hF;
        low_col    = !col_s_q[0] ? 2'd0 : !col_s_q[1] ? 2'd1 : !col_s_q[2] ? 2'd2 : 2'd3;
        cap_high   = col_s_q[cap_col_q];
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        cap_col_d  = cap_col_q;
        div_d      = div_q;
        deb_d      = deb_q;
        key_code_d = key_code_q;
        case (state_q)
            SCAN: begin
                div_d = div_q == DIV_LAST ? '0 : div_q + 1'b1;
                if (div_q == DIV_LAST && !all_high) begin
                    cap_col_d = low_col;
                    deb_d     = '0;
                    state_d   = DEBOUNCE;
                end else if (div_q == DIV_LAST) begin
                    row_idx_d = row_idx_q + 2'd1;
                end
            end
            DEBOUNCE: begin
                if (cap_high) begin
                    state_d   = SCAN;
                    row_idx_d = row_idx_q + 2'd1;
                    div_d     = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d    = ACCEPT;
                    key_code_d = KEYMAP[{row_idx_q, cap_col_q, 2'b00} +: 4];
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            ACCEPT: state_d = HOLD;
            HOLD: begin
                if (all_high) begin
                    state_d = RELEASE;
                    deb_d   = '0;
                end
            end
            RELEASE: begin
                if (!all_high) begin
                    state_d = HOLD;
                end else if (deb_q == DEB_LAST) begin
                    state_d   = SCAN;
                    row_idx_d = row_idx_q + 2'd1;
                    div_d     = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        accept       = state_q == ACCEPT;
        data_d       = data_q;
        digit_cnt_d  = digit_cnt_q;
        new_entry_d  = new_entry_q;
        data_ready_d = accept && key_code_q == 4'hF ? 1'b1 : rd_ack ? 1'b0 : data_ready_q;
        if (accept && key_code_q <= 4'hD) begin
            if (new_entry_q) begin
                data_d      = {12'h000, key_code_q};
                digit_cnt_d = 3'd1;
                new_entry_d = 1'b0;
`ifdef KEYPAD_DIGIT_LIMIT_EN
            end else if (digit_cnt_q < 3'd4) begin
                data_d      = {data_q[11:0], key_code_q};
                digit_cnt_d = digit_cnt_q + 3'd1;
            end
`else
            end else begin
                data_d      = {data_q[11:0], key_code_q};
                digit_cnt_d = digit_cnt_q < 3'd4 ? digit_cnt_q + 3'd1 : 3'd4;
            end
`endif
        end
        if (accept && key_code_q == 4'hE) begin
            data_d      = digit_cnt_q == 3'd0 ? data_q : {4'h0, data_q[15:4]};
            digit_cnt_d = digit_cnt_q == 3'd0 ? 3'd0 : digit_cnt_q - 3'd1;
            new_entry_d = 1'b0;
        end
        if (accept && key_code_q == 4'hF)
            new_entry_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_m_q      <= 4'hF;
            col_s_q      <= 4'hF;
            state_q      <= SCAN;
            row_idx_q    <= 2'd0;
            cap_col_q    <= 2'd0;
            div_q        <= '0;
            deb_q        <= '0;
            data_q       <= 16'h0000;
            key_code_q   <= 4'h0;
            data_ready_q <= 1'b0;
            digit_cnt_q  <= 3'd0;
            new_entry_q  <= 1'b0;
        end else begin
            col_m_q      <= col;
            col_s_q      <= col_m_q;
            state_q      <= state_d;
            row_idx_q    <= row_idx_d;
            cap_col_q    <= cap_col_d;
            div_q        <= div_d;
            deb_q        <= deb_d;
            data_q       <= data_d;
            key_code_q   <= key_code_d;
            data_ready_q <= data_ready_d;
            digit_cnt_q  <= digit_cnt_d;
            new_entry_q  <= new_entry_d;
        end
    end

    assign row                = ~(4'b0001 << row_idx_q);
    assign keyboard_read_data = data_q;
    assign key_code           = key_code_q;
    assign key_valid          = state_q == ACCEPT;
    assign data_ready         = data_ready_q;
    assign digit_cnt          = digit_cnt_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed bench for keypad_scan_ctrl with a modelled 4x4 key matrix.
module tb_keypad_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row, col, key_code;
    logic        rd_ack, key_valid, data_ready;
    logic [15:0] kbd;
    logic [2:0]  digit_cnt;
    logic        key_on = 1'b0;
    logic [1:0]  key_r = 2'd0, key_c = 2'd0;
    logic        force_en = 1'b0;
    logic [3:0]  force_col = 4'hF;
    logic        ack_man = 1'b0, ack_kv = 1'b0;
    logic [3:0]  row_snap;
    int          vectors = 0, miscompares = 0, kv_cnt = 0, exp_kv = 0;

    always #5 clk = ~clk;

    // A pressed key pulls its column low only while its row is driven low.
    assign col    = force_en ? force_col : (key_on && !row[key_r]) ? ~(4'b0001 << key_c) : 4'hF;
    assign rd_ack = ack_man | (ack_kv & key_valid);

    always @(posedge clk) if (key_valid === 1'b1) kv_cnt <= kv_cnt + 1;

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEB_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .rd_ack(rd_ack),
        .keyboard_read_data(kbd), .key_code(key_code), .key_valid(key_valid),
        .data_ready(data_ready), .digit_cnt(digit_cnt)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c, input logic [3:0] code);
        key_r  = r;
        key_c  = c;
        key_on = 1'b1;
        tick(40);
        key_on = 1'b0;
        tick(20);
        exp_kv++;
        check("kv_count", 32'(kv_cnt), 32'(exp_kv));
        check("key_code", 32'(key_code), 32'(code));
    endtask

    task automatic pulse_ack();
        ack_man = 1'b1;
        tick(1);
        ack_man = 1'b0;
        tick(1);
    endtask

    initial begin
        tick(2);
        check("rst_row", 32'(row), 32'h0000_000E);
        check("rst_data", 32'(kbd), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_ready", 32'(data_ready), 32'h0);
        check("rst_cnt", 32'(digit_cnt), 32'h0);
        rst = 1'b0;
        tick(1);

        press(2'd1, 2'd2, 4'h6);
        check("six_data", 32'(kbd), 32'h0006);
        check("six_cnt", 32'(digit_cnt), 32'd1);

        force_col = 4'b1110;
        force_en  = 1'b1;
        tick(7);
        rst = 1'b1;
        #1;
        check("arst_row", 32'(row), 32'h0000_000E);
        check("arst_data", 32'(kbd), 32'h0);
        check("arst_cnt", 32'(digit_cnt), 32'h0);
        check("arst_code", 32'(key_code), 32'h0);
        check("arst_valid", 32'(key_valid), 32'h0);
        tick(2);
        force_en = 1'b0;
        rst      = 1'b0;
        tick(3);
        check("restart_row0", 32'(row), 32'h0000_000E);
        tick(1);
        check("restart_row1", 32'(row), 32'h0000_000D);
        check("arst_no_key", 32'(kv_cnt), 32'(exp_kv));

        press(2'd0, 2'd0, 4'h1);
        press(2'd0, 2'd1, 4'h2);
        press(2'd0, 2'd2, 4'h3);
        press(2'd0, 2'd3, 4'hA);
        press(2'd3, 2'd2, 4'hF);
        check("enter_data", 32'(kbd), 32'h123A);
        check("enter_ready", 32'(data_ready), 32'd1);
        pulse_ack();
        check("ack_ready", 32'(data_ready), 32'd0);
        check("ack_data", 32'(kbd), 32'h123A);
        press(2'd1, 2'd1, 4'h5);
        check("new_data", 32'(kbd), 32'h0005);
        check("new_cnt", 32'(digit_cnt), 32'd1);

        force_col = 4'b1011;
        force_en  = 1'b1;
        tick(3);
        force_en  = 1'b0;
        tick(30);
        check("glitch_no_key", 32'(kv_cnt), 32'(exp_kv));
        row_snap = row;
        tick(4);
        check("glitch_rotate", 32'(row), 32'({row_snap[2:0], row_snap[3]}));

        press(2'd3, 2'd2, 4'hF);
        pulse_ack();
        check("ack2_ready", 32'(data_ready), 32'd0);
        press(2'd0, 2'd0, 4'h1);
        press(2'd0, 2'd1, 4'h2);
        press(2'd3, 2'd0, 4'hE);
        check("bs_data", 32'(kbd), 32'h0001);
        check("bs_cnt", 32'(digit_cnt), 32'd1);
        press(2'd3, 2'd0, 4'hE);
        press(2'd3, 2'd0, 4'hE);
        check("bs0_data", 32'(kbd), 32'h0000);
        check("bs0_cnt", 32'(digit_cnt), 32'd0);
        ack_kv = 1'b1;
        press(2'd3, 2'd2, 4'hF);
        ack_kv = 1'b0;
        check("set_wins_ready", 32'(data_ready), 32'd1);
        check("set_wins_data", 32'(kbd), 32'h0000);

        press(2'd0, 2'd0, 4'h1);
        press(2'd0, 2'd1, 4'h2);
        press(2'd0, 2'd2, 4'h3);
        press(2'd1, 2'd0, 4'h4);
        check("four_data", 32'(kbd), 32'h1234);
        press(2'd1, 2'd1, 4'h5);
`ifdef KEYPAD_DIGIT_LIMIT_EN
        check("fifth_data", 32'(kbd), 32'h1234);
`else
        check("fifth_data", 32'(kbd), 32'h2345);
`endif
        check("fifth_cnt", 32'(digit_cnt), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Scans a 4x4 matrix keypad, debounces presses and decodes each key to a 4-bit code.
- Assembles up to four hex digits into the 16-bit value the IO block returns to the CPU at keyboard address offset 2'b11.
- Sits beside the IO block and owns the keypad pins.
- Provides a ready flag that the CPU-side read acknowledge clears.

Parameters:
- SCAN_DIV, 20000: clk cycles each row stays driven before its columns are sampled.
- DEB_CYCLES, 200000: consecutive stable clk cycles required to accept a press or a release.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous reset, active-high.
- row  out  4  keypad row drive, active-low, one row low at a time.
- col  in  4  keypad column sense, active-low, pulled up, asynchronous to clk.
- rd_ack  in  1  one-cycle pulse when the CPU reads keyboard data (IORead with addr 2'b11).
- keyboard_read_data  out  16  assembled digit value.
- key_code  out  4  code of the last accepted key.
- key_valid  out  1  one-cycle pulse per accepted key.
- data_ready  out  1  set by the enter key, cleared by rd_ack.
- digit_cnt  out  3  number of digits held, 0..4.

Behaviour:
- Reset values: row=4'b1110, keyboard_read_data=0, key_code=0, key_valid=0, data_ready=0, digit_cnt=0, state=SCAN, row_idx=0, new_entry=0.
- Reset is asynchronous and aborts any state immediately.
- col passes through a 2-flop synchronizer (2-cycle latency). All decisions use the synchronized value colS.
- row=~(4'b0001<<row_idx) in every state.
- Keymap, row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E(*) 0 F(#) D
- FSM states:
  - SCAN: div counts 0..SCAN_DIV-1. At div==SCAN_DIV-1:
    - If colS!=4'hF: capture row_idx and the lowest-index low column. Multiple lows resolve to the lowest column. Clear deb, go to DEBOUNCE.
    - Otherwise: row_idx increments with wrap 3->0, div=0.
  - DEBOUNCE: row held.
    - If colS[cap_col]==1: return to SCAN with row_idx advanced.
    - Else deb++. When deb reaches DEB_CYCLES-1 with the bit still low, go to ACCEPT.
  - ACCEPT: one cycle. key_valid=1, key_code=decoded code, action applied. Next state HOLD.
  - HOLD: wait for colS==4'hF, then go to RELEASE with deb=0.
  - RELEASE: any low column returns to HOLD.
    - After DEB_CYCLES consecutive all-high cycles: go to SCAN, row_idx advanced, div=0.
- Actions taken in ACCEPT:
  - Digit (code 0..D):
    - If new_entry: data={12'h0,code}, digit_cnt=1, new_entry=0.
    - Else if digit_cnt<4: data={data[11:0],code}, digit_cnt++.
    - Else (digit_cnt==4): see Optional Feature.
  - E (backspace): data={4'h0,data[15:4]}, digit_cnt=max(digit_cnt-1,0). At digit_cnt==0 data is unchanged. new_entry is cleared.
  - F (enter): data_ready=1, new_entry=1, data unchanged.
- rd_ack clears data_ready. If rd_ack and an F accept occur in the same cycle, the set wins.
- rd_ack has no effect on data or digit_cnt.
- key_valid is high only in ACCEPT. A key held indefinitely produces exactly one pulse.
- Latency from a stable press to key_valid: at most 2 + 4*SCAN_DIV + DEB_CYCLES cycles.

Optional Feature:
- Macro: KEYPAD_DIGIT_LIMIT_EN.
- Defined: a digit key at digit_cnt==4 is ignored. key_valid still pulses and key_code updates; data and digit_cnt are unchanged.
- Undefined: the digit shifts in and the oldest digit is discarded. data={data[11:0],code}, digit_cnt stays 4.

Test Plan (SCAN_DIV=4, DEB_CYCLES=8):
- Assert rst mid-DEBOUNCE with col held low -> row=1110 and all outputs 0 immediately; scanning restarts from row 0 after release.
- Hold row1/col2 ('6') 40 cycles, then release 20 cycles -> exactly one key_valid pulse, key_code=6, data=0x0006, digit_cnt=1.
- Press 1,2,3,A,F -> data=0x123A, data_ready=1. Pulse rd_ack -> data_ready=0. Press 5 -> data=0x0005, digit_cnt=1.
- Drive col bit low for 3 cycles, then high -> no key_valid, state returns to SCAN, row rotation continues.
- Press 1,2,E -> data=0x0001, digit_cnt=1. Press E twice -> data=0x0000, digit_cnt=0. Issue rd_ack in the same cycle as an F accept -> data_ready=1.
- Press 1,2,3,4,5 -> without macro data=0x2345, digit_cnt=4; with KEYPAD_DIGIT_LIMIT_EN data=0x1234, digit_cnt=4.
